decrypt_sequencer: RTL and testbench

//  Hardware controller for program 3 (decrypt, depad, flag corruption). Sits beside DM1 in TopLevel.

---
 rtl/decrypt_sequencer_pkg.sv | 42 ++++
 rtl/decrypt_sequencer_lfsr7.sv | 44 ++++
 rtl/decrypt_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_decrypt_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decrypt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package   : decrypt_pkg
// Purpose   : Shared constants, FSM state type and tap-pattern table for the
//             program-3 decrypt sequencer (decrypt, depad, flag corruption).
// Revision  : 1.0  initial release
// ============================================================================
package decrypt_pkg;

  localparam logic [7:0] MSG_BASE     = 8'd64;  // ciphertext base in data memory
  localparam logic [7:0] OUT_BASE     = 8'd0;   // plaintext output base
  localparam int         MSG_LEN      = 64;     // bytes processed and written
  localparam int         PRE_MIN      = 10;     // guaranteed preamble spaces
  localparam logic [7:0] SPACE        = 8'h20;

  localparam logic [5:0] LAST_IDX     = 6'(MSG_LEN - 1);
  localparam logic [3:0] PRE_LAST     = 4'(PRE_MIN - 1);
  localparam logic [3:0] NUM_PAT_LAST = 4'd8;
  localparam logic [3:0] TAP_NONE     = 4'hF;

  // Candidate feedback tap masks, tried in index order during the search
  localparam logic [6:0] LFSR_TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                           7'h69, 7'h5C, 7'h7E, 7'h7B};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEARCH  = 3'd2,
    S_SKIP    = 3'd3,
    S_COPY_RD = 3'd4,
    S_COPY_WR = 3'd5,
    S_FILL    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Out-of-range pattern indices fall back to pattern 0
  function automatic logic [6:0] taps_for(input logic [3:0] idx);
    taps_for = (idx <= NUM_PAT_LAST) ? LFSR_TAPS[idx] : LFSR_TAPS[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/decrypt_sequencer_lfsr7.sv
`default_nettype none
// ============================================================================
// Module    : lfsr7
// Purpose   : 7-bit Fibonacci LFSR with parallel load and single-step enable.
//             next = {s[5:0], ^(s & taps)}; load has priority over step.
// Revision  : 1.0  initial release
// ============================================================================
module lfsr7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       step,
  input  logic [6:0] taps,
  output logic [6:0] state,
  output logic [6:0] next_state
);

  logic [6:0] state_q, state_d;

  assign next_state = {state_q[5:0], ^(state_q & taps)};
  assign state      = state_q;

  // Select between hold, reload and one shift step
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = next_state;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : decrypt_sequencer
// Purpose   : Recovers LFSR taps/seed from the space preamble of the message
//             at MSG_BASE, decrypts it, strips leading spaces, flags parity
//             errors in bit 7 and writes 64 bytes to OUT_BASE.
// Options   : DSEQ_ERR_COUNT_EN - adds err_count[6:0], the number of written
//             bytes carrying a parity-error flag.
// Revision  : 1.0  initial release
// ============================================================================
module decrypt_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [3:0] tap_sel
`ifdef DSEQ_ERR_COUNT_EN
  ,
  output logic [6:0] err_count
`endif
);
  import decrypt_pkg::*;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] cnt_q, cnt_d;          // load index, then preamble index k
  logic [5:0] rd_idx_q, rd_idx_d;
  logic [5:0] wr_idx_q, wr_idx_d;
  logic [3:0] pidx_q, pidx_d;        // pattern under test / in use
  logic [3:0] tap_sel_q, tap_sel_d;
  logic [6:0] init_q, init_d;
  logic [6:0] pre_buf_q [PRE_MIN];
  logic [6:0] pre_buf_d [PRE_MIN];
  logic [7:0] data_q, data_d;

  logic       lfsr_load, lfsr_step;
  logic [6:0] lfsr_taps, lfsr_state, lfsr_next;
  logic [6:0] w_plain;
  logic       w_perr, w_launch;

  assign lfsr_taps = taps_for(pidx_q);
  assign w_plain   = mem_rdata[6:0] ^ lfsr_state;
  assign w_perr    = mem_rdata[7] ^ (^mem_rdata[6:0]);
  assign w_launch  = (state_q == S_IDLE) && start_q && !Start;
  assign tap_sel   = tap_sel_q;

  lfsr7 u_lfsr (
    .clk        (Clk),
    .rst        (Reset),
    .load       (lfsr_load),
    .load_val   (init_q),
    .step       (lfsr_step),
    .taps       (lfsr_taps),
    .state      (lfsr_state),
    .next_state (lfsr_next)
  );

  // Next-state, memory interface and LFSR control
  always_comb begin
    state_d   = state_q;
    start_d   = Start;
    cnt_d     = cnt_q;
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    pidx_d    = pidx_q;
    tap_sel_d = tap_sel_q;
    init_d    = init_q;
    pre_buf_d = pre_buf_q;
    data_d    = data_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    Ack       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_launch) begin
          state_d   = S_LOAD;
          cnt_d     = '0;
          tap_sel_d = TAP_NONE;
        end
      end
      S_LOAD: begin
        mem_addr         = MSG_BASE + {4'd0, cnt_q};
        pre_buf_d[cnt_q] = mem_rdata[6:0];
        if (cnt_q == '0) begin
          init_d = mem_rdata[6:0] ^ SPACE[6:0];
        end
        if (cnt_q == PRE_LAST) begin
          state_d   = S_SEARCH;
          cnt_d     = 4'd1;
          pidx_d    = '0;
          lfsr_load = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SEARCH: begin
        // One preamble byte per cycle against the next LFSR value
        if (init_q == '0) begin
          tap_sel_d = TAP_NONE;
          pidx_d    = '0;
          state_d   = S_SKIP;
          rd_idx_d  = '0;
          lfsr_load = 1'b1;
        end else if ((pre_buf_q[cnt_q] ^ lfsr_next) == SPACE[6:0]) begin
          if (cnt_q == PRE_LAST) begin
            tap_sel_d = pidx_q;
            state_d   = S_SKIP;
            rd_idx_d  = '0;
            lfsr_load = 1'b1;
          end else begin
            cnt_d     = cnt_q + 4'd1;
            lfsr_step = 1'b1;
          end
        end else if (pidx_q == NUM_PAT_LAST) begin
          tap_sel_d = TAP_NONE;
          pidx_d    = '0;
          state_d   = S_SKIP;
          rd_idx_d  = '0;
          lfsr_load = 1'b1;
        end else begin
          pidx_d    = pidx_q + 4'd1;
          cnt_d     = 4'd1;
          lfsr_load = 1'b1;
        end
      end
      S_SKIP: begin
        // A non-space or parity-error byte is left unconsumed for COPY_RD
        mem_addr = MSG_BASE + {2'd0, rd_idx_q};
        if ((w_plain == SPACE[6:0]) && !w_perr) begin
          lfsr_step = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            state_d  = S_FILL;
            wr_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + 6'd1;
          end
        end else begin
          state_d  = S_COPY_RD;
          wr_idx_d = '0;
        end
      end
      S_COPY_RD: begin
        mem_addr = MSG_BASE + {2'd0, rd_idx_q};
        data_d   = {w_perr, w_plain};
        state_d  = S_COPY_WR;
      end
      S_COPY_WR: begin
        mem_addr  = OUT_BASE + {2'd0, wr_idx_q};
        mem_we    = 1'b1;
        mem_wdata = data_q;
        lfsr_step = 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          // Nothing skipped means the copy alone filled all 64 slots
          if (wr_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_FILL;
            wr_idx_d = wr_idx_q + 6'd1;
          end
        end else begin
          rd_idx_d = rd_idx_q + 6'd1;
          wr_idx_d = wr_idx_q + 6'd1;
          state_d  = S_COPY_RD;
        end
      end
      S_FILL: begin
        mem_addr  = OUT_BASE + {2'd0, wr_idx_q};
        mem_we    = 1'b1;
        mem_wdata = SPACE;
        if (wr_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          wr_idx_d = wr_idx_q + 6'd1;
        end
      end
      S_DONE: begin
        Ack = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Start high aborts from anywhere and suppresses any pending write
    if (Start) begin
      state_d = S_IDLE;
      mem_we  = 1'b0;
    end
  end

  // Control and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      pidx_q    <= '0;
      tap_sel_q <= TAP_NONE;
      init_q    <= '0;
      pre_buf_q <= '{default: '0};
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      pidx_q    <= pidx_d;
      tap_sel_q <= tap_sel_d;
      init_q    <= init_d;
      pre_buf_q <= pre_buf_d;
      data_q    <= data_d;
    end
  end

`ifdef DSEQ_ERR_COUNT_EN
  logic [6:0] err_cnt_q, err_cnt_d;

  // Count flagged bytes actually written; cleared at each launch
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (w_launch) begin
      err_cnt_d = '0;
    end else if (mem_we && mem_wdata[7]) begin
      err_cnt_d = err_cnt_q + 7'd1;
    end
  end

  // Error counter register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : tb_decrypt_sequencer
// Purpose   : Self-checking bench for decrypt_sequencer: directed vector
//             table, a mid-copy reset sequence and randomized messages, all
//             checked against a behavioural decrypt model.
// Options   : DSEQ_ERR_COUNT_EN - also checks err_count.
// Revision  : 1.0  initial release
// ============================================================================
module tb_decrypt_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [3:0] tap_sel;
`ifdef DSEQ_ERR_COUNT_EN
  logic [6:0] err_count;
`endif

  decrypt_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tap_sel   (tap_sel)
`ifdef DSEQ_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Data memory: asynchronous read, synchronous write
  logic [7:0] mem [256];
  logic [7:0] cipher [64];
  logic [6:0] plain [64];
  logic       load_req = 1'b0;
  int         wr_count = 0;
  int         bad_addr = 0;

  assign mem_rdata = mem[mem_addr];

  // Bulk preload of the message region, or DUT write capture
  always @(posedge Clk) begin
    if (load_req) begin
      for (int j = 0; j < 64; j++) begin
        mem[j]      <= 8'hA5;
        mem[64 + j] <= cipher[j];
      end
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
      if (mem_addr >= 8'd64) bad_addr <= bad_addr + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] step7(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  function automatic logic [6:0] tap_val(input int i);
    case (i)
      0: return 7'h60;  1: return 7'h48;  2: return 7'h78;
      3: return 7'h72;  4: return 7'h6A;  5: return 7'h69;
      6: return 7'h5C;  7: return 7'h7E;  default: return 7'h7B;
    endcase
  endfunction

  function automatic string text_of(input int id);
    case (id)
      0: return "Mr. Watson, come here. I want to see you.";
      1: return " Knowledge comes, but wisdom lingers.    ";
      default: return "";
    endcase
  endfunction

  // Plaintext = pre spaces, text, then spaces to 64 bytes
  task automatic set_plain_text(input int pre, input int id);
    string txt;
    byte   b;
    txt = text_of(id);
    for (int j = 0; j < 64; j++) begin
      plain[j] = 7'h20;
      if (j >= pre && (j - pre) < txt.len()) begin
        b        = txt[j - pre];
        plain[j] = b[6:0];
      end
    end
  endtask

  // Encrypt plain[] with the given taps and seed, even parity in bit 7
  task automatic encrypt(input int tidx, input logic [6:0] init);
    logic [6:0] s;
    logic [6:0] c;
    s = init;
    for (int j = 0; j < 64; j++) begin
      c         = plain[j] ^ s;
      cipher[j] = {^c, c};
      s         = step7(s, tap_val(tidx));
    end
  endtask

  // Reference model of the expected output image
  logic [7:0] exp_out [64];
  logic [3:0] exp_tap;
  int         exp_err;

  task automatic model();
    logic [6:0] init, s, t, pl;
    logic       pe, ok, skipping;
    logic [7:0] q[$];
    init    = cipher[0][6:0] ^ 7'h20;
    exp_tap = 4'hF;
    if (init != 7'd0) begin
      for (int p = 0; p < 9; p++) begin
        s  = init;
        ok = 1'b1;
        for (int k = 1; k <= 9; k++) begin
          s = step7(s, tap_val(p));
          if ((cipher[k][6:0] ^ s) != 7'h20) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          exp_tap = 4'(p);
          break;
        end
      end
    end
    t        = tap_val((exp_tap == 4'hF) ? 0 : int'(exp_tap));
    s        = init;
    skipping = 1'b1;
    for (int j = 0; j < 64; j++) begin
      pl = cipher[j][6:0] ^ s;
      pe = cipher[j][7] ^ (^cipher[j][6:0]);
      if (!(skipping && pl == 7'h20 && !pe)) begin
        skipping = 1'b0;
        q.push_back({pe, pl});
      end
      s = step7(s, t);
    end
    while (q.size() < 64) q.push_back(8'h20);
    exp_err = 0;
    for (int j = 0; j < 64; j++) begin
      exp_out[j] = q[j];
      if (q[j][7]) exp_err++;
    end
  endtask

  int wr0, bad0, cycles;

  // Preload, pulse Start, release to launch, wait (bounded) for Ack
  task automatic run_dut();
    Start    = 1'b1;
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    @(negedge Clk);
    wr0    = wr_count;
    bad0   = bad_addr;
    Start  = 1'b0;
    cycles = 0;
    while (!Ack && cycles < 400) begin
      @(negedge Clk);
      cycles++;
    end
  endtask

  task automatic check_results(input string tag);
    int diffs, first;
    check({tag, "_ack"}, {31'd0, Ack}, 32'd1);
    n_cmp++;
    if (cycles > 300) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles, expected <= 300", tag, cycles);
    end
    check({tag, "_tap_sel"}, {28'd0, tap_sel}, {28'd0, exp_tap});
    check({tag, "_writes"}, wr_count - wr0, 32'd64);
    check({tag, "_stray_writes"}, bad_addr - bad0, 32'd0);
    diffs = 0;
    first = -1;
    for (int j = 0; j < 64; j++) begin
      if (mem[j] !== exp_out[j]) begin
        diffs++;
        if (first < 0) first = j;
      end
    end
    if (diffs != 0)
      $display("  %s: first differing byte %0d is %02h, model %02h", tag, first, mem[first], exp_out[first]);
    check({tag, "_out_bytes_differing"}, diffs, 32'd0);
`ifdef DSEQ_ERR_COUNT_EN
    check({tag, "_err_count"}, {25'd0, err_count}, exp_err);
`endif
  endtask

  typedef struct {
    int         text_id;
    int         pre;
    int         tidx;
    logic [6:0] init;
    int         flip_idx;
    int         flip_bit;
    logic [3:0] exp_tap;
    logic [7:0] exp_out0;
    int         exp_err;
  } vec_t;

  vec_t vecs [5];
  vec_t v;
  int   waited;

  initial begin
    // text, pre, taps idx, seed, flip idx, flip bit, tap_sel, out[0], errors
    vecs[0] = '{0, 10, 0, 7'h01, -1, 0, 4'h0, 8'h4D, 0};  // Watson, clean
    vecs[1] = '{1, 15, 8, 7'h01, -1, 0, 4'h8, 8'h4B, 0};  // Knowledge, 16 skipped
    vecs[2] = '{0, 10, 0, 7'h01, 30, 2, 4'h0, 8'h4D, 1};  // cipher[30] corrupted
    vecs[3] = '{2, 10, 0, 7'h01, -1, 0, 4'h0, 8'h20, 0};  // all spaces
    vecs[4] = '{0, 10, 0, 7'h01,  5, 3, 4'hF, 8'hA8, 1};  // preamble corrupted

    Reset = 1'b1;
    Start = 1'b0;
    #2;
    check("reset_ack",       {31'd0, Ack},       32'd0);
    check("reset_mem_we",    {31'd0, mem_we},    32'd0);
    check("reset_mem_addr",  {24'd0, mem_addr},  32'd0);
    check("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("reset_tap_sel",   {28'd0, tap_sel},   32'hF);
    @(negedge Clk);
    Reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      set_plain_text(v.pre, v.text_id);
      encrypt(v.tidx, v.init);
      if (v.flip_idx >= 0) cipher[v.flip_idx][v.flip_bit] = ~cipher[v.flip_idx][v.flip_bit];
      model();
      run_dut();
      check_results($sformatf("vec%0d", i));
      check($sformatf("vec%0d_tap_sel_fixed", i), {28'd0, tap_sel}, {28'd0, v.exp_tap});
      check($sformatf("vec%0d_out0", i), {24'd0, mem[0]}, {24'd0, v.exp_out0});
      if (v.flip_idx >= v.pre)
        check($sformatf("vec%0d_perr_flag", i), {31'd0, mem[v.flip_idx - v.pre][7]}, 32'd1);
    end

    // Reset in the middle of the copy phase, then relaunch
    set_plain_text(10, 0);
    encrypt(0, 7'h01);
    model();
    Start    = 1'b1;
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    @(negedge Clk);
    Start  = 1'b0;
    waited = 0;
    while (!mem_we && waited < 300) begin
      @(negedge Clk);
      waited++;
    end
    check("midrun_copy_reached", {31'd0, mem_we}, 32'd1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("midrun_reset_ack",    {31'd0, Ack},     32'd0);
    check("midrun_reset_mem_we", {31'd0, mem_we},  32'd0);
    check("midrun_reset_tap",    {28'd0, tap_sel}, 32'hF);
    @(negedge Clk);
    Reset = 1'b0;
    run_dut();
    check_results("relaunch");

    // Randomized messages, taps, seeds and single-bit corruption
    for (int r = 0; r < 16; r++) begin
      int         pre, tidx;
      logic [6:0] init;
      pre  = int'($urandom_range(30, 10));
      tidx = int'($urandom_range(8, 0));
      init = ($urandom_range(7, 0) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
      for (int j = 0; j < 64; j++) begin
        if (j < pre)       plain[j] = 7'h20;
        else if (j == pre) plain[j] = 7'($urandom_range(126, 33));
        else               plain[j] = 7'($urandom_range(126, 32));
      end
      encrypt(tidx, init);
      if ($urandom_range(1, 0) == 1) begin
        int fi, fb;
        fi = int'($urandom_range(63, 0));
        fb = int'($urandom_range(7, 0));
        cipher[fi][fb] = ~cipher[fi][fb];
      end
      model();
      run_dut();
      check_results($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
